// File: rtl/dsdac_demod_if.sv
// ============================================================================
// Module      : dsdac_demod_if
// Description : DAC drive bus into the demodulator and estimate bus out of it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dsdac_demod_if #(
  parameter int DIN_W  = 16,
  parameter int DOUT_W = 32
);
  logic [DOUT_W-1:0] dac_p;
  logic [DOUT_W-1:0] dac_n;
  logic [DIN_W-1:0]  din_est;
  logic              est_valid;

  modport master (
    output dac_p,
    output dac_n,
    input  din_est,
    input  est_valid
  );

  modport slave (
    input  dac_p,
    input  dac_n,
    output din_est,
    output est_valid
  );
endinterface

`default_nettype wire

// File: rtl/dsdac_demod.sv
// ============================================================================
// Module      : dsdac_demod
// Description : Loopback monitor that decodes the one-hot delta-sigma DAC drive
//               and decimates it into an estimate of the modulator input word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsdac_demod #(
  parameter int DIN_W      = 16,
  parameter int DOUT_BITS  = 5,
  parameter int DOUT_W     = 2**DOUT_BITS,
  parameter int DEC_BITS   = 8,
  parameter int SETTLE_CYC = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  wire logic                 clk_ref,
  input  wire logic                 n_rst,
  input  wire logic                 VDD,
  input  wire logic                 VSS,
  input  wire logic                 enable,
  input  wire logic                 clr_err,
  dsdac_demod_if.slave              bus,
  output logic [DOUT_BITS-1:0]      level_idx,
  output logic                      code_err,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam int c_AW    = DOUT_BITS + DEC_BITS;
  localparam int c_PAD   = DIN_W - c_AW;
  localparam int c_SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [DOUT_BITS-1:0] c_IDX_RST  = DOUT_BITS'(DOUT_W/2 - 1);
  localparam logic [DOUT_W-1:0]    c_ONE      = {{(DOUT_W-1){1'b0}}, 1'b1};
  localparam logic [DEC_BITS-1:0]  c_CNT_LAST = '1;
  localparam logic [c_SET_W-1:0]   c_SET_LAST = c_SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_ACCUM  = 2'd2;

  // Supply pins are carried for netlist compatibility only.
  wire w_unused_supply = VDD ^ VSS;

  logic [DOUT_BITS-1:0] r_level_idx;
  logic                 r_code_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [c_AW-1:0]      r_acc;
  logic [DEC_BITS-1:0]  r_cnt;
  logic [c_SET_W-1:0]   r_set_cnt;
  logic [DIN_W-1:0]     r_din_est;
  logic                 r_est_valid;

  logic [DOUT_BITS-1:0] w_idx;
  logic                 w_onehot;
  logic                 w_cmp_ok;
  logic                 w_valid;
  logic                 w_err;
  logic                 w_settle_done;
  logic                 w_settle_inc;
  logic                 w_acc_add;
  logic                 w_win_end;
  logic [c_AW-1:0]      w_sum;
  logic [DIN_W-1:0]     w_est;

  // --------------------------------------------------------------------------
  // Stage 1: sample decode and code-integrity check
  // --------------------------------------------------------------------------
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DOUT_W; i++) begin
      if (bus.dac_p[i]) begin
        w_idx = DOUT_BITS'(i);
      end
    end
  end

  // x & (x-1) clears the lowest set bit, so zero means at most one bit set.
  assign w_onehot = (bus.dac_p != '0) && ((bus.dac_p & (bus.dac_p - c_ONE)) == '0);
  assign w_cmp_ok = (bus.dac_n == ~bus.dac_p);
  assign w_valid  = w_onehot && w_cmp_ok;
  assign w_err    = !w_valid && enable;

  always_ff @(posedge clk_ref or negedge n_rst) begin
    if (!n_rst) begin
      r_level_idx <= c_IDX_RST;
      r_code_err  <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      if (w_valid) begin
        r_level_idx <= w_idx;
      end
      if (clr_err) begin
        r_code_err <= 1'b0;
        r_err_cnt  <= '0;
      end else if (w_err) begin
        r_code_err <= 1'b1;
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: decimation FSM
  // --------------------------------------------------------------------------
  assign w_settle_done = (r_set_cnt == c_SET_LAST);

  always_ff @(posedge clk_ref or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = (SETTLE_CYC == 0) ? S_ACCUM : S_SETTLE;
        S_SETTLE: w_state_nxt = w_settle_done ? S_ACCUM : S_SETTLE;
        S_ACCUM:  w_state_nxt = S_ACCUM;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Enable gates every action so a drop on a window-end edge loses the window.
  always_comb begin
    w_settle_inc = 1'b0;
    w_acc_add    = 1'b0;
    w_win_end    = 1'b0;
    if (enable) begin
      case (r_state)
        S_SETTLE: w_settle_inc = 1'b1;
        S_ACCUM: begin
          w_acc_add = 1'b1;
          w_win_end = (r_cnt == c_CNT_LAST);
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator, window counter and estimate register
  // --------------------------------------------------------------------------
  assign w_sum = r_acc + c_AW'(r_level_idx);
  assign w_est = DIN_W'(w_sum) << c_PAD;

  always_ff @(posedge clk_ref or negedge n_rst) begin
    if (!n_rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_set_cnt   <= '0;
      r_din_est   <= '0;
      r_est_valid <= 1'b0;
    end else begin
      r_est_valid <= w_win_end;

      if (w_acc_add) begin
        if (w_win_end) begin
          r_acc     <= '0;
          r_cnt     <= '0;
          r_din_est <= w_est;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + DEC_BITS'(1);
        end
      end else begin
        r_acc <= '0;
        r_cnt <= '0;
      end

      if (w_settle_inc && !w_settle_done) begin
        r_set_cnt <= r_set_cnt + c_SET_W'(1);
      end else begin
        r_set_cnt <= '0;
      end
    end
  end

  assign level_idx     = r_level_idx;
  assign code_err      = r_code_err;
  assign err_cnt       = r_err_cnt;
  assign bus.din_est   = r_din_est;
  assign bus.est_valid = r_est_valid;

endmodule

`default_nettype wire

// File: tb/tb_dsdac_demod.sv
// ============================================================================
// Module      : tb_dsdac_demod
// Description : Directed self-checking bench for the delta-sigma demodulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsdac_demod;

  logic       clk_ref = 1'b0;
  logic       n_rst;
  logic       VDD = 1'b1;
  logic       VSS = 1'b0;
  logic       enable;
  logic       clr_err;
  logic [4:0] level_idx;
  logic       code_err;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  dsdac_demod_if #(.DIN_W(16), .DOUT_W(32)) bus ();

  dsdac_demod #(
    .DIN_W(16), .DOUT_BITS(5), .DOUT_W(32), .DEC_BITS(8), .SETTLE_CYC(2), .ERR_CNT_W(8)
  ) dut (
    .clk_ref   (clk_ref),
    .n_rst     (n_rst),
    .VDD       (VDD),
    .VSS       (VSS),
    .enable    (enable),
    .clr_err   (clr_err),
    .bus       (bus),
    .level_idx (level_idx),
    .code_err  (code_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk_ref = ~clk_ref;

  task automatic set_onehot(input int b);
    bus.dac_p = 32'd1 << b;
    bus.dac_n = ~(32'd1 << b);
  endtask

  task automatic step();
    @(posedge clk_ref);
    #1;
  endtask

  // Edges until est_valid is seen (first edge counts as 1); max+1 on timeout.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (n <= max) begin
      step();
      n++;
      if (bus.est_valid) break;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; enable = 1'b0; clr_err = 1'b0;
    set_onehot(15);
    repeat (3) step();
    checks++; if (level_idx !== 5'd15) begin errors++; $display("FAIL rst_level_idx got=%0d exp=15", level_idx); end
    checks++; if (bus.din_est !== 16'h0) begin errors++; $display("FAIL rst_din_est got=%h exp=0000", bus.din_est); end
    checks++; if (bus.est_valid !== 1'b0) begin errors++; $display("FAIL rst_est_valid got=%b exp=0", bus.est_valid); end
    checks++; if (code_err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err got=%b/%0d exp=0/0", code_err, err_cnt); end
    n_rst = 1'b1;
    step();
    // Invalid sample while idle: held, not flagged.
    bus.dac_p = 32'h0; bus.dac_n = 32'h0;
    step();
    checks++; if (code_err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL idle_err got=%b/%0d exp=0/0", code_err, err_cnt); end
    checks++; if (level_idx !== 5'd15) begin errors++; $display("FAIL idle_hold got=%0d exp=15", level_idx); end
    set_onehot(15);
    step();
  endtask

  task automatic test_mid_scale();
    int n;
    enable = 1'b1;
    wait_valid(300, n);
    checks++; if (n !== 259) begin errors++; $display("FAIL first_latency got=%0d exp=259", n); end
    checks++; if (bus.din_est !== 16'h7800) begin errors++; $display("FAIL mid_din_est got=%h exp=7800", bus.din_est); end
    step();
    checks++; if (bus.est_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width got=%b exp=0", bus.est_valid); end
  endtask

  task automatic test_full_scale();
    int n;
    set_onehot(31);
    wait_valid(300, n);
    wait_valid(300, n);
    checks++; if (n !== 256) begin errors++; $display("FAIL fs_period got=%0d exp=256", n); end
    checks++; if (bus.din_est !== 16'hF800) begin errors++; $display("FAIL fs_din_est got=%h exp=F800", bus.din_est); end
    wait_valid(300, n);
    checks++; if (n !== 256 || bus.din_est !== 16'hF800) begin errors++; $display("FAIL fs_repeat got=%0d/%h exp=256/F800", n, bus.din_est); end
  endtask

  task automatic test_alternating();
    int pulses = 0;
    for (int i = 0; i < 700 && pulses < 2; i++) begin
      set_onehot((i % 2 == 1) ? 11 : 10);
      step();
      if (bus.est_valid) pulses++;
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL alt_pulses got=%0d exp=2", pulses); end
    checks++; if (bus.din_est !== 16'h5400) begin errors++; $display("FAIL alt_din_est got=%h exp=5400", bus.din_est); end
  endtask

  task automatic test_code_err();
    set_onehot(7);
    repeat (3) step();
    checks++; if (level_idx !== 5'd7) begin errors++; $display("FAIL decode_7 got=%0d exp=7", level_idx); end
    bus.dac_p = 32'h3; bus.dac_n = ~32'h3;
    step();
    checks++; if (level_idx !== 5'd7) begin errors++; $display("FAIL multihot_hold got=%0d exp=7", level_idx); end
    checks++; if (code_err !== 1'b1 || err_cnt !== 8'd1) begin errors++; $display("FAIL multihot_err got=%b/%0d exp=1/1", code_err, err_cnt); end
    set_onehot(7);
    step();
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL valid_no_count got=%0d exp=1", err_cnt); end
    clr_err = 1'b1; bus.dac_p = 32'h3; bus.dac_n = ~32'h3;
    step();
    checks++; if (code_err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL clr_priority got=%b/%0d exp=0/0", code_err, err_cnt); end
    clr_err = 1'b0;
    set_onehot(7);
    step();
  endtask

  task automatic test_saturation();
    bus.dac_p = 32'd1 << 9; bus.dac_n = 32'd1 << 9;
    repeat (200) step();
    checks++; if (err_cnt !== 8'd200) begin errors++; $display("FAIL cnt_200 got=%0d exp=200", err_cnt); end
    repeat (100) step();
    checks++; if (err_cnt !== 8'd255 || code_err !== 1'b1) begin errors++; $display("FAIL cnt_sat got=%0d/%b exp=255/1", err_cnt, code_err); end
    checks++; if (level_idx !== 5'd7) begin errors++; $display("FAIL mismatch_hold got=%0d exp=7", level_idx); end
    set_onehot(7);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL sat_clear got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_enable_drop();
    int n;
    int seen = 0;
    set_onehot(20);
    wait_valid(300, n);
    wait_valid(300, n);
    checks++; if (bus.din_est !== 16'hA000) begin errors++; $display("FAIL b20_din_est got=%h exp=A000", bus.din_est); end
    // Next window-end edge is 256 edges after the pulse just seen.
    repeat (255) @(posedge clk_ref);
    #1;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.est_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL drop_valid got=%0d pulses exp=0", seen); end
    checks++; if (bus.din_est !== 16'hA000) begin errors++; $display("FAIL drop_din_hold got=%h exp=A000", bus.din_est); end
    set_onehot(5);
    enable = 1'b1;
    wait_valid(300, n);
    checks++; if (n !== 259) begin errors++; $display("FAIL reenable_latency got=%0d exp=259", n); end
    checks++; if (bus.din_est !== 16'h2800) begin errors++; $display("FAIL reenable_din_est got=%h exp=2800", bus.din_est); end
  endtask

  initial begin
    test_reset();
    test_mid_scale();
    test_full_scale();
    test_alternating();
    test_code_err();
    test_saturation();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
